// File: rtl/romulus_tbc_sequencer.sv
// Romulus TBC control sequencer: expands one command into per-cycle datapath strobes and the SKINNY round-constant stream.
// Optional TBC completion counter is enabled by defining ROMULUS_TBC_SEQ_PERF_EN.
module romulus_tbc_sequencer #(
  parameter int ROUNDS   = 40,
  parameter int UNROLL   = 1,
  parameter int BUSWIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [BUSWIDTH/8-1:0] cmd_decrypt,
  input  logic [7:0]            cmd_domain,
  input  logic                  cmd_tk1s,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [6*UNROLL-1:0]   constant,
  output logic [BUSWIDTH/8-1:0] decrypt,
  output logic [7:0]            domain,
  output logic                  srst,
  output logic                  senc,
  output logic                  sen,
  output logic                  xrst,
  output logic                  xenc,
  output logic                  xen,
  output logic                  yrst,
  output logic                  yenc,
  output logic                  yen,
  output logic                  zrst,
  output logic                  zenc,
  output logic                  zen,
  output logic                  erst,
  output logic                  correct_cnt,
  output logic                  tk1s,
  output logic [31:0]           tbc_count,
  output logic [1:0]            fsm_state
);

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, so the requester holds its command while busy.

  localparam int NCYC = ROUNDS / UNROLL;
  localparam int CW   = $clog2(NCYC + 1);

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_LOAD_KEY  = 3'd1;
  localparam logic [2:0] OP_LOAD_TWK  = 3'd2;
  localparam logic [2:0] OP_CLR_STATE = 3'd3;
  localparam logic [2:0] OP_ABSORB    = 3'd4;
  localparam logic [2:0] OP_TBC       = 3'd5;
  localparam logic [2:0] OP_CNT_RESET = 3'd6;
  localparam logic [2:0] OP_CNT_ADV   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_ROUND = 2'd2,
    S_CORR  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [2:0]            op_q;
  logic [BUSWIDTH/8-1:0] dec_q;
  logic [7:0]            dom_q;
  logic                  tk1s_q;
  logic [CW-1:0]         rnd_q;
  logic [5:0]            rc_q;
  logic [5:0]            rc_walk;
  logic [6*UNROLL-1:0]   rc_slots;
  logic                  accept;
  logic                  last_round;

  function automatic logic [5:0] rc_step(input logic [5:0] r);
    return {r[4:0], ~(r[5] ^ r[4])};
  endfunction

  assign accept     = cmd_valid && (state_q == S_IDLE);
  assign last_round = (rnd_q == CW'(NCYC - 1));
  assign fsm_state  = state_q;

  // Each slot holds the next LFSR value; the last one becomes the register update.
  always_comb begin
    rc_walk  = rc_q;
    rc_slots = '0;
    for (int k = 0; k < UNROLL; k++) begin
      rc_walk           = rc_step(rc_walk);
      rc_slots[6*k +: 6] = rc_walk;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (cmd_op == OP_TBC)      state_d = S_ROUND;
          else if (cmd_op != OP_NOP) state_d = S_EXEC;
        end
      end
      S_EXEC:  state_d = S_IDLE;
      S_ROUND: begin
        if (abort)           state_d = S_IDLE;
        else if (last_round) state_d = S_CORR;
      end
      S_CORR:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    constant    = '0;
    decrypt     = '0;
    srst        = 1'b0;
    senc        = 1'b0;
    sen         = 1'b0;
    xrst        = 1'b0;
    xenc        = 1'b0;
    xen         = 1'b0;
    yrst        = 1'b0;
    yenc        = 1'b0;
    yen         = 1'b0;
    zrst        = 1'b0;
    zenc        = 1'b0;
    zen         = 1'b0;
    erst        = 1'b0;
    correct_cnt = 1'b0;
    case (state_q)
      S_IDLE: cmd_ready = 1'b1;
      S_EXEC: begin
        busy = 1'b1;
        done = 1'b1;
        case (op_q)
          OP_LOAD_KEY:  xrst = 1'b1;
          OP_LOAD_TWK:  yrst = 1'b1;
          OP_CLR_STATE: begin
            srst = 1'b1;
            erst = 1'b1;
          end
          OP_ABSORB: begin
            sen     = 1'b1;
            decrypt = dec_q;
          end
          OP_CNT_RESET: zrst = 1'b1;
          OP_CNT_ADV: begin
            zen         = 1'b1;
            correct_cnt = 1'b1;
          end
          default: ;
        endcase
      end
      S_ROUND: begin
        busy     = 1'b1;
        constant = rc_slots;
        sen      = 1'b1;
        senc     = 1'b1;
        xen      = 1'b1;
        xenc     = 1'b1;
        yen      = 1'b1;
        yenc     = 1'b1;
        zen      = 1'b1;
        zenc     = 1'b1;
      end
      S_CORR: begin
        // Inverse tweakey step restores TKX/TKY; TKZ advances with the domain.
        busy = 1'b1;
        done = 1'b1;
        xen  = 1'b1;
        yen  = 1'b1;
        zen  = 1'b1;
      end
      default: ;
    endcase
  end

  assign domain = dom_q;
  assign tk1s   = busy ? tk1s_q : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= OP_NOP;
      dec_q  <= '0;
      dom_q  <= '0;
      tk1s_q <= 1'b0;
    end else if (accept) begin
      op_q   <= cmd_op;
      dec_q  <= cmd_decrypt;
      dom_q  <= cmd_domain;
      tk1s_q <= cmd_tk1s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd_q <= '0;
      rc_q  <= 6'h00;
    end else begin
      if (state_q == S_ROUND && state_d == S_ROUND) rnd_q <= rnd_q + CW'(1);
      else                                          rnd_q <= '0;
      if (state_q == S_ROUND && !abort) rc_q <= rc_walk;
      else                              rc_q <= 6'h00;
    end
  end

`ifdef ROMULUS_TBC_SEQ_PERF_EN
  logic [31:0] tbc_count_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tbc_count_q <= '0;
    else if (state_q == S_CORR && tbc_count_q != 32'hFFFF_FFFF)
      tbc_count_q <= tbc_count_q + 32'd1;
  end
  assign tbc_count = tbc_count_q;
`else
  assign tbc_count = 32'd0;
`endif

endmodule

// File: tb/tb_romulus_tbc_sequencer.sv
// Directed bench for romulus_tbc_sequencer: an UNROLL=1 instance for most checks, an UNROLL=2 instance for the unrolled constant stream.
module tb_romulus_tbc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid, cmd_valid2;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_decrypt;
  logic [7:0]  cmd_domain;
  logic        cmd_tk1s;
  logic        abort;

  logic        cmd_ready, busy, done;
  logic [5:0]  constant;
  logic [15:0] decrypt;
  logic [7:0]  domain;
  logic srst, senc, sen, xrst, xenc, xen, yrst, yenc, yen, zrst, zenc, zen, erst, correct_cnt, tk1s;
  logic [31:0] tbc_count;
  logic [1:0]  fsm_state;

  logic        u2_cmd_ready, u2_busy, u2_done;
  logic [11:0] u2_constant;
  logic [15:0] u2_decrypt;
  logic [7:0]  u2_domain;
  logic u2_srst, u2_senc, u2_sen, u2_xrst, u2_xenc, u2_xen, u2_yrst, u2_yenc, u2_yen;
  logic u2_zrst, u2_zenc, u2_zen, u2_erst, u2_correct_cnt, u2_tk1s;
  logic [31:0] u2_tbc_count;
  logic [1:0]  u2_fsm_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_tbc;

  // SKINNY round constants, rounds 1..40
  logic [5:0] rc_tab [40] = '{
    6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F,
    6'h1E, 6'h3C, 6'h39, 6'h33, 6'h27, 6'h0E, 6'h1D, 6'h3A, 6'h35, 6'h2B,
    6'h16, 6'h2C, 6'h18, 6'h30, 6'h21, 6'h02, 6'h05, 6'h0B, 6'h17, 6'h2E,
    6'h1C, 6'h38, 6'h31, 6'h23, 6'h06, 6'h0D, 6'h1B, 6'h36, 6'h2D, 6'h1A
  };

  romulus_tbc_sequencer #(.ROUNDS(40), .UNROLL(1), .BUSWIDTH(128)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_decrypt(cmd_decrypt), .cmd_domain(cmd_domain), .cmd_tk1s(cmd_tk1s),
    .abort(abort), .busy(busy), .done(done), .constant(constant), .decrypt(decrypt),
    .domain(domain), .srst(srst), .senc(senc), .sen(sen), .xrst(xrst), .xenc(xenc), .xen(xen),
    .yrst(yrst), .yenc(yenc), .yen(yen), .zrst(zrst), .zenc(zenc), .zen(zen), .erst(erst),
    .correct_cnt(correct_cnt), .tk1s(tk1s), .tbc_count(tbc_count), .fsm_state(fsm_state)
  );

  romulus_tbc_sequencer #(.ROUNDS(40), .UNROLL(2), .BUSWIDTH(128)) dut2 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid2), .cmd_ready(u2_cmd_ready),
    .cmd_op(cmd_op), .cmd_decrypt(cmd_decrypt), .cmd_domain(cmd_domain), .cmd_tk1s(cmd_tk1s),
    .abort(abort), .busy(u2_busy), .done(u2_done), .constant(u2_constant), .decrypt(u2_decrypt),
    .domain(u2_domain), .srst(u2_srst), .senc(u2_senc), .sen(u2_sen), .xrst(u2_xrst),
    .xenc(u2_xenc), .xen(u2_xen), .yrst(u2_yrst), .yenc(u2_yenc), .yen(u2_yen),
    .zrst(u2_zrst), .zenc(u2_zenc), .zen(u2_zen), .erst(u2_erst),
    .correct_cnt(u2_correct_cnt), .tk1s(u2_tk1s), .tbc_count(u2_tbc_count),
    .fsm_state(u2_fsm_state)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one command to the selected instance; returns #1 after the accept edge.
  task automatic send_cmd(input bit u2, input logic [2:0] op, input logic [15:0] dec,
                          input logic [7:0] dom, input logic tk);
    int guard = 0;
    while (!(u2 ? u2_cmd_ready : cmd_ready) && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) check("ready_timeout", 64'd0, 64'd1);
    cmd_op      = op;
    cmd_decrypt = dec;
    cmd_domain  = dom;
    cmd_tk1s    = tk;
    if (u2) cmd_valid2 = 1'b1;
    else    cmd_valid  = 1'b1;
    tick();
    cmd_valid  = 1'b0;
    cmd_valid2 = 1'b0;
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_valid2 = 1'b0; cmd_op = 3'd0;
    cmd_decrypt = '0; cmd_domain = '0; cmd_tk1s = 1'b0; abort = 1'b0;
`ifdef ROMULUS_TBC_SEQ_PERF_EN
    exp_tbc = 32'd1;
`else
    exp_tbc = 32'd0;
`endif
    #12;
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_const", constant, 0);
    check("rst_state", fsm_state, 0);
    check("rst_tbc_count", tbc_count, 0);
    rst_n = 1'b1;
    tick();

    // NOP: accepted, no state change, no done
    send_cmd(0, 3'd0, 16'h0, 8'h11, 1'b0);
    check("nop_state", fsm_state, 0);
    check("nop_done", done, 0);
    check("nop_ready", cmd_ready, 1);

    // LOAD_KEY then LOAD_TWEAK with valid held high
    cmd_op = 3'd1; cmd_valid = 1'b1;
    tick();
    check("lk_xrst", xrst, 1);
    check("lk_ready", cmd_ready, 0);
    check("lk_done", done, 1);
    cmd_op = 3'd2;
    tick();
    check("lk_xrst_off", xrst, 0);
    check("lk_yrst_early", yrst, 0);
    check("lk_ready_back", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    check("lt_yrst", yrst, 1);
    check("lt_done", done, 1);
    check("lt_xrst", xrst, 0);
    tick();
    check("lt_yrst_off", yrst, 0);

    // CLR_STATE
    send_cmd(0, 3'd3, 16'h0, 8'h0, 1'b0);
    check("clr_srst", srst, 1);
    check("clr_erst", erst, 1);
    check("clr_done", done, 1);

    // ABSORB with mask 00FF
    send_cmd(0, 3'd4, 16'h00FF, 8'h0, 1'b0);
    check("abs_decrypt", decrypt, 16'h00FF);
    check("abs_sen", sen, 1);
    check("abs_senc", senc, 0);
    tick();
    check("abs_decrypt_off", decrypt, 0);
    check("abs_sen_off", sen, 0);

    // CNT_RESET, CNT_ADV
    send_cmd(0, 3'd6, 16'h0, 8'h0, 1'b0);
    check("cr_zrst", zrst, 1);
    send_cmd(0, 3'd7, 16'h0, 8'h0, 1'b0);
    check("ca_zen", zen, 1);
    check("ca_zenc", zenc, 0);
    check("ca_corr", correct_cnt, 1);

    // Full TBC, UNROLL=1
    send_cmd(0, 3'd5, 16'h0, 8'h5A, 1'b1);
    check("tbc_strobes", {sen, senc, xen, xenc, yen, yenc, zen, zenc}, 8'hFF);
    check("tbc_tk1s", tk1s, 1);
    for (int r = 0; r < 40; r++) begin
      check($sformatf("rc%0d", r + 1), constant, rc_tab[r]);
      if (r == 20) check("tbc_mid_done", done, 0);
      if (r < 39) tick();
    end
    tick();
    check("corr_done", done, 1);
    check("corr_en", {xen, yen, zen}, 3'b111);
    check("corr_enc", {senc, xenc, yenc, zenc}, 4'b0000);
    check("corr_sen", sen, 0);
    check("corr_cc", correct_cnt, 0);
    check("corr_const", constant, 0);
    check("corr_domain", domain, 8'h5A);
    tick();
    check("post_ready", cmd_ready, 1);
    check("post_done", done, 0);
    check("post_tk1s", tk1s, 0);
    check("post_domain", domain, 8'h5A);
    check("tbc_count_1", tbc_count, exp_tbc);

    // UNROLL=2 instance
    send_cmd(1, 3'd5, 16'h0, 8'h00, 1'b0);
    check("u2_first_const", u2_constant, 12'h0C1);
    cyc = 1;
    while (!u2_done && cyc < 50) begin
      tick();
      cyc++;
      if (cyc == 20) check("u2_last_const", u2_constant, 12'h6AD);
    end
    check("u2_done_cycle", cyc, 21);
    tick();
    check("u2_ready_back", u2_cmd_ready, 1);

    // Abort on ROUND cycle 5
    send_cmd(0, 3'd5, 16'h0, 8'h33, 1'b0);
    repeat (4) tick();
    check("ab_in_round", fsm_state, 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_state", fsm_state, 0);
    check("ab_done", done, 0);
    check("ab_xen", xen, 0);
    check("ab_ready", cmd_ready, 1);
    check("ab_tbc_count", tbc_count, exp_tbc);

    // Restart after abort, then reset on ROUND cycle 10
    send_cmd(0, 3'd5, 16'h0, 8'h44, 1'b0);
    check("ab_restart_rc", constant, 6'h01);
    repeat (9) tick();
    check("mid_rc10", constant, rc_tab[9]);
    #1 rst_n = 1'b0;
    #1;
    check("mr_strobes", {sen, senc, xen, xenc, yen, yenc, zen, zenc, done}, 9'h0);
    check("mr_const", constant, 0);
    check("mr_ready", cmd_ready, 1);
    check("mr_tbc_count", tbc_count, 0);
    #1 rst_n = 1'b1;
    tick();
    send_cmd(0, 3'd5, 16'h0, 8'h00, 1'b0);
    check("mr_restart_rc", constant, 6'h01);
    repeat (40) tick();
    check("mr_corr_done", done, 1);
    tick();
    check("mr_tbc_count_after", tbc_count, exp_tbc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
